// File: rtl/sync_fifo_ext_if.sv
// Handshake bundle between a same-clock producer/consumer and sync_fifo_ext.
// Ports: write side (wr_en, din, full, prog_full, overflow), read side (rd_en, dout,
//        valid, empty, prog_empty, underflow) and the occupancy count fifo_num.
// master drives requests and data; slave (the FIFO) drives data and status back.
interface sync_fifo_ext_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 10
);
    // write side
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] din;
    logic                  full;
    logic                  prog_full;
    logic                  overflow;
    // read side
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] dout;
    logic                  valid;
    logic                  empty;
    logic                  prog_empty;
    logic                  underflow;
    // occupancy
    logic [ADDR_WIDTH:0]   fifo_num;

    modport master (
        output wr_en, din, rd_en,
        input  full, prog_full, overflow,
        input  dout, valid, empty, prog_empty, underflow, fifo_num
    );

    modport slave (
        input  wr_en, din, rd_en,
        output full, prog_full, overflow,
        output dout, valid, empty, prog_empty, underflow, fifo_num
    );
endinterface

// File: rtl/sync_fifo_ext.sv
// Single-clock FIFO, register-array storage, standard or first-word-fall-through read.
// Latency: standard read data 1 cycle after rd_en; FWFT head word visible 2 edges after the write.
// Backpressure: writes dropped while full, reads dropped while empty; each drop pulses overflow/underflow.
//
// Ports:
//   sys_clk_i  - sole clock, rising edge
//   rst_i      - synchronous active-high reset
//   bus        - sync_fifo_ext_if.slave: wr_en/din in, rd_en in, dout/valid/status/fifo_num out
module sync_fifo_ext #(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 10,
    parameter int READ_MODE      = 0,
    parameter int PROG_FULL_NUM  = 1000,
    parameter int PROG_EMPTY_NUM = 4
) (
    input  logic                sys_clk_i,
    input  logic                rst_i,
    sync_fifo_ext_if.slave      bus
);
    localparam int                  DEPTH     = 1 << ADDR_WIDTH;
    localparam bit                  FWFT      = (READ_MODE != 0);
    localparam logic [ADDR_WIDTH:0] DEPTH_C   = (ADDR_WIDTH+1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0] PFULL_C   = (ADDR_WIDTH+1)'(PROG_FULL_NUM);
    localparam logic [ADDR_WIDTH:0] PEMPTY_C  = (ADDR_WIDTH+1)'(PROG_EMPTY_NUM);
    localparam logic [ADDR_WIDTH:0] CNT_ONE   = (ADDR_WIDTH+1)'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];   // storage, intentionally not reset
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [ADDR_WIDTH:0]   r_ram_count;     // words held in r_mem only
    logic [DATA_WIDTH-1:0] r_dout;
    // Standard mode: "dout was refreshed by last edge".
    // FWFT mode: output register occupied (head word presented on dout).
    logic                  r_out_vld;
    logic                  r_overflow;
    logic                  r_underflow;

    // ------------------------------------------------------------------
    // Decode from registered state
    // ------------------------------------------------------------------
    logic                  w_full;
    logic                  w_ram_nonempty;
    logic                  w_empty;
    logic                  w_wr_acc;
    logic                  w_rd_acc;
    logic                  w_ram_rd;
    logic                  w_out_vld_nxt;
    logic [ADDR_WIDTH:0]   w_fifo_num;

    assign w_full         = (r_ram_count == DEPTH_C);
    assign w_ram_nonempty = (r_ram_count != '0);

    // In FWFT the reader only sees the output register, so emptiness is its occupancy.
    assign w_empty = FWFT ? ~r_out_vld : ~w_ram_nonempty;

    assign w_wr_acc = bus.wr_en & ~w_full;
    assign w_rd_acc = bus.rd_en & ~w_empty;

    // A RAM read happens on an accepted standard read, or in FWFT whenever the
    // output register is (or is about to become) free and the RAM has a word.
    // Refilling on the pop edge itself is what keeps FWFT bubble-free.
    assign w_ram_rd = FWFT ? (w_ram_nonempty & (~r_out_vld | w_rd_acc))
                           : w_rd_acc;

    // FWFT: register stays loaded unless popped with nothing behind it.
    assign w_out_vld_nxt = FWFT ? (w_ram_rd | (r_out_vld & ~w_rd_acc))
                                : w_rd_acc;

    assign w_fifo_num = FWFT ? (r_ram_count + (ADDR_WIDTH+1)'(r_out_vld))
                             : r_ram_count;

    // ------------------------------------------------------------------
    // Storage write port
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk_i) begin
        if (w_wr_acc && !rst_i) begin
            r_mem[r_wr_ptr] <= bus.din;
        end
    end

    // ------------------------------------------------------------------
    // Pointers, count, output register and event pulses
    // ------------------------------------------------------------------
    always_ff @(posedge sys_clk_i) begin
        if (rst_i) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_ram_count <= '0;
            r_dout      <= '0;
            r_out_vld   <= 1'b0;
            r_overflow  <= 1'b0;
            r_underflow <= 1'b0;
        end else begin
            r_overflow  <= bus.wr_en & w_full;
            r_underflow <= bus.rd_en & w_empty;
            r_out_vld   <= w_out_vld_nxt;

            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + PTR_ONE;
            end

            if (w_ram_rd) begin
                r_rd_ptr <= r_rd_ptr + PTR_ONE;
                r_dout   <= r_mem[r_rd_ptr];
            end

            // Count tracks RAM occupancy only; a same-edge write and RAM read cancel.
            case ({w_wr_acc, w_ram_rd})
                2'b10:   r_ram_count <= r_ram_count + CNT_ONE;
                2'b01:   r_ram_count <= r_ram_count - CNT_ONE;
                default: r_ram_count <= r_ram_count;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Outputs: all purely decoded from registers above
    // ------------------------------------------------------------------
    assign bus.full       = w_full;
    assign bus.prog_full  = (w_fifo_num >= PFULL_C);
    assign bus.overflow   = r_overflow;
    assign bus.dout       = r_dout;
    assign bus.valid      = r_out_vld;
    assign bus.empty      = w_empty;
    assign bus.prog_empty = (w_fifo_num <= PEMPTY_C);
    assign bus.underflow  = r_underflow;
    assign bus.fifo_num   = w_fifo_num;

endmodule

// File: doc/sync_fifo_ext.md
# sync_fifo_ext

Parametrised single-clock FIFO with internal storage, selectable read mode (standard or first-word-fall-through), registered status flags, sticky-free overflow/underflow pulses, and write/read protection against full/empty. It is the general-purpose buffer for same-clock datapaths. It replaces ad-hoc FIFO instances wherever the caller must not corrupt pointers by writing when full or reading when empty.

## Interface

Parameters:
- DATA_WIDTH, 8, word width in bits.
- ADDR_WIDTH, 10, RAM depth DEPTH = 2^ADDR_WIDTH; legal range ≥ 2.
- READ_MODE, 0, 0 = standard (1-cycle read latency), 1 = FWFT.
- PROG_FULL_NUM, 1000, prog_full threshold in words; legal range 1..CAP.
- PROG_EMPTY_NUM, 4, prog_empty threshold in words; must be < PROG_FULL_NUM.

Ports:
- sys_clk_i  in  1  sole clock; all logic on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- wr_en  in  1  write request.
- din  in  DATA_WIDTH  write data.
- full  out  1  RAM full; writes are rejected while high.
- prog_full  out  1  fifo_num ≥ PROG_FULL_NUM.
- overflow  out  1  one-cycle pulse: a write was rejected.
- rd_en  in  1  read request (standard) / pop (FWFT).
- dout  out  DATA_WIDTH  read data.
- valid  out  1  dout holds a freshly read word (standard) / equals ~empty (FWFT).
- empty  out  1  no word available to read.
- prog_empty  out  1  fifo_num ≤ PROG_EMPTY_NUM.
- underflow  out  1  one-cycle pulse: a read was rejected.
- fifo_num  out  ADDR_WIDTH+1  words held (RAM plus FWFT output register).

## Operation

- CAP = DEPTH (READ_MODE=0) or DEPTH+1 (READ_MODE=1).
- Storage: internal register array, DEPTH × DATA_WIDTH, not reset. Write/read pointers ADDR_WIDTH bits; they wrap naturally from DEPTH-1 to 0.
- ram_count register: ADDR_WIDTH+1 bits, 0..DEPTH.
  - +1 on an accepted write only; -1 on a RAM read only; unchanged when both occur.
- Write accepted iff wr_en & ~full. A rejected write leaves pointers and memory unchanged and produces overflow = 1 for exactly the next cycle.
- Standard mode:
  - Read accepted iff rd_en & ~empty. On the edge, dout ← mem[rd_ptr] and valid ← 1.
  - If no read is accepted, valid ← 0 and dout holds.
  - empty = (ram_count == 0); fifo_num = ram_count.
- FWFT mode:
  - Output register out_vld/dout sits after the RAM. When out_vld = 0 and ram_count > 0, the head word moves into dout on the next edge.
  - Pop accepted iff rd_en & out_vld. On a pop edge:
    - if ram_count > 0 (after any same-edge write not counted), dout ← next word with no bubble;
    - otherwise out_vld ← 0.
  - empty = ~out_vld; valid = out_vld; fifo_num = ram_count + out_vld.
- Rejected read (rd_en & empty): produces underflow = 1 for the next cycle; no state change.
- full = (ram_count == DEPTH).
- All flags are decoded from registered state only. No combinational path from wr_en or rd_en to any output.
- Simultaneous write and read:
  - When full: the write is rejected (overflow) and the read is accepted.
  - When empty: the read is rejected (underflow) and the write is accepted.
- Reset (rst_i = 1 at an edge) overrides everything, including a mid-burst transfer. Results:
  - pointers = 0, ram_count = 0, out_vld = 0;
  - dout = 0, valid = 0, empty = 1, full = 0;
  - prog_empty = 1, prog_full = 0;
  - overflow = 0, underflow = 0, fifo_num = 0.

## Timing

- Write at edge N: full/fifo_num/prog_* reflect it after edge N.
  - Standard mode: empty falls after edge N.
  - FWFT mode: empty falls after edge N+1, with dout valid at the same time.
- Standard read accepted at edge N: dout/valid are valid after edge N (one-cycle latency). Back-to-back reads give one word per cycle.
- Throughput: one write and one read per cycle sustained, in both modes.
- overflow/underflow: asserted in the cycle after the offending edge, for one cycle per rejected request.

## Test plan

All scenarios use DATA_WIDTH=8, ADDR_WIDTH=3 (DEPTH 8), PROG_FULL_NUM=6, PROG_EMPTY_NUM=2.

- **Reset state, both modes:** hold rst_i 2 cycles, then idle.
  - Required: empty=1, prog_empty=1, full=0, valid=0, dout=0x00, fifo_num=0.
- **Standard fill and wrap:** write 0x10..0x17 (8 words), then read 8.
  - After the 6th write: prog_full=1. After the 8th write: full=1.
  - A 9th write of 0xFF gives overflow=1 for one cycle and fifo_num stays 8.
  - Reads return 0x10..0x17, each one cycle after rd_en, with valid=1.
  - After the last read: empty=1.
- **Wrap-around:** write 5, read 5, then write 0x20..0x27 and read all.
  - Required: data order is preserved across the pointer wrap.
- **FWFT:** write 0xA5 at edge N.
  - Required: empty=1 after N; after N+1, empty=0, dout=0xA5, fifo_num=1.
  - Fill to CAP 9: full=1 when fifo_num=9.
  - Pop every cycle: 9 consecutive distinct words with no bubble.
- **Simultaneous events:**
  - full + wr_en + rd_en: one word is read, overflow=1, fifo_num 8 → 7.
  - empty + wr_en + rd_en: underflow=1, fifo_num 0 → 1.
  - Standard mode at fifo_num=3 with wr_en + rd_en: fifo_num stays 3.
- **Reset mid-operation:** assert rst_i during a 4-word burst at fifo_num=5.
  - Required: the next cycle shows reset values; the next write/read returns the new data, not stale words.
